// File: rtl/br_param.sv
// br_param: parametrised register bank with NRD combinational read ports,
// one clocked write port, optional write-to-read bypass, optional
// hardwired-zero entry 0 and a per-entry pending scoreboard.
// After reset (or CLR) a clear sequencer zeroes one entry per cycle;
// LISTO rises once every entry has been cleared.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clearing mem[idx]; reads return 0, BUSY=0, traffic ignored
// ST_RUN  | normal operation; reads, writes and scoreboard active
module br_param #(
  parameter int W       = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NRD*AW-1:0] DL,
  output logic [NRD*W-1:0]  op,
  output logic [NRD-1:0]    BUSY,
  input  logic [AW-1:0]     DE,
  input  logic [W-1:0]      DATO,
  input  logic              WE,
  input  logic              SB_SET,
  input  logic [AW-1:0]     SB_DE,
  input  logic              CLR,
  output logic              LISTO
);

  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam bit            ZR       = (ZERO_R0 != 0);
  localparam bit            BYP      = (BYPASS != 0);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            listo_q, listo_d;
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [W-1:0]    mem_q [DEPTH];

  logic            run;
  logic            wr_ok;
  logic            sb_ok;

  assign run   = (state_q == ST_RUN);
  // A write lands only in RUN, not in a CLR cycle, and never on a hardwired r0.
  assign wr_ok = run && WE && !CLR && !(ZR && (DE == '0));
  assign sb_ok = run && SB_SET && !CLR && !(ZR && (SB_DE == '0));
  assign LISTO = listo_q;

  // Next-state for the sequencer FSM, ready flag and pending scoreboard.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    listo_d = listo_q;
    pend_d  = pend_q;
    case (state_q)
      ST_INIT: begin
        pend_d = '0;
        idx_d  = idx_q + IDX_ONE;
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          listo_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (CLR) begin
          state_d = ST_INIT;
          idx_d   = '0;
          listo_d = 1'b0;
          pend_d  = '0;
        end else begin
          // Clear first so a same-cycle set on the same entry wins.
          if (WE)    pend_d[DE]    = 1'b0;
          if (sb_ok) pend_d[SB_DE] = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
        listo_d = 1'b0;
        pend_d  = '0;
      end
    endcase
  end

  // Sequencer FSM state, clear index, registered LISTO and pending bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      listo_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      listo_q <= listo_d;
      pend_q  <= pend_d;
    end
  end

  // Storage array: cleared one entry per cycle in INIT, written in RUN.
  // No reset here on purpose; the clear sequencer owns initialisation.
  always_ff @(posedge CLK) begin
    if (!run) begin
      mem_q[idx_q] <= '0;
    end else if (wr_ok) begin
      mem_q[DE] <= DATO;
    end
  end

  logic [AW-1:0] rd_a;
  logic          rd_hit;
  logic          busy_hit;

  // Read ports: r0 zero beats bypass, bypass beats the array; all zero in INIT.
  always_comb begin
    op       = '0;
    BUSY     = '0;
    rd_a     = '0;
    rd_hit   = 1'b0;
    busy_hit = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rd_a     = DL[i*AW +: AW];
      rd_hit   = BYP && wr_ok && (DE == rd_a);
      busy_hit = BYP && WE && (DE == rd_a);
      if (run) begin
        if (ZR && (rd_a == '0)) begin
          op[i*W +: W] = '0;
        end else if (rd_hit) begin
          op[i*W +: W] = DATO;
        end else begin
          op[i*W +: W] = mem_q[rd_a];
        end
        BUSY[i] = pend_q[rd_a] && !busy_hit;
      end
    end
  end

endmodule

// File: doc/br_param.md
Name: br_param

Overview:
Parametrised register bank and successor of the combinational 32x32 bank. It has NRD read ports, one clocked write port, optional write-to-read bypass, and an optional hardwired-zero register 0. A per-register pending scoreboard marks registers whose producer has not yet written back. A post-reset clear sequencer zeroes the array one entry per cycle, so there is no file preload. The block sits between decode (read addresses, scoreboard set) and writeback (DE/DATO/WE).

Parameters:
W, 32, data width in bits
AW, 5, address width; DEPTH = 2**AW entries
NRD, 2, number of read ports (1..4)
ZERO_R0, 1, 1 = entry 0 always reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
DL  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
op  out  NRD*W  read data; port i uses bits [i*W +: W]
BUSY  out  NRD  BUSY[i]=1: register addressed by port i is pending
DE  in  AW  write address
DATO  in  W  write data
WE  in  1  write enable
SB_SET  in  1  mark SB_DE pending (instruction issued)
SB_DE  in  AW  register to mark pending
CLR  in  1  restart the clear sequence
LISTO  out  1  bank initialised and accepting traffic

Behaviour:
- Reset (RST_N=0, asynchronous): state=INIT, idx=0, all pending bits=0, LISTO=0. Outputs while in INIT: op=0, BUSY=0.
- INIT state:
  - Each cycle: mem[idx]<=0, idx<=idx+1.
  - After writing idx=DEPTH-1, go to RUN; LISTO=1 from the next cycle. Total of DEPTH cycles after reset release.
  - WE, SB_SET and CLR are ignored in INIT. Pending bits are held at 0.
- RUN state:
  - CLR=1: go to INIT on the next edge, idx=0, LISTO=0, pending bits cleared. A CLR-cycle write is dropped.
  - Write: on a rising edge with WE=1, mem[DE]<=DATO, unless ZERO_R0=1 and DE=0.
  - Read (combinational): op_i = mem[DL_i].
    - If BYPASS=1, WE=1, DE=DL_i and the write is not suppressed: op_i = DATO (write-first).
    - If ZERO_R0=1 and DL_i=0: op_i = 0, with priority over bypass.
    - With BYPASS=0, new data is visible the cycle after the write.
- Scoreboard (RUN only):
  - Edge with SB_SET=1: pend[SB_DE]<=1.
  - Edge with WE=1: pend[DE]<=0.
  - SB_SET and WE on the same register in the same cycle: set wins, because the new producer supersedes.
  - Entry 0 is never set when ZERO_R0=1.
  - BUSY[i] = pend[DL_i] and not (BYPASS and WE and DE==DL_i). A bypassed write resolves the hazard in the same cycle.
- Read ports are independent. Any number of ports may address the same register, with identical results.
- A reset assertion mid-INIT or mid-RUN restarts INIT immediately. Contents are not guaranteed until LISTO=1.

Test Plan:
- Reset release, W=32 AW=5 -> LISTO=0 for exactly 32 cycles, then 1; every DL reads 0x00000000.
- RUN, WE=1 DE=5 DATO=0xDEADBEEF, DL0=5 same cycle -> BYPASS=1: op0=0xDEADBEEF immediately; BYPASS=0: old value, then 0xDEADBEEF next cycle.
- ZERO_R0=1, WE=1 DE=0 DATO=0x12345678 -> op reads 0 for DL=0; SB_SET SB_DE=0 -> BUSY stays 0.
- SB_SET SB_DE=7, DL1=7 -> BUSY[1]=1 from the next cycle. Later WE DE=7 DATO=0x55 -> BUSY[1]=0 in the write cycle (bypass) and op1=0x55.
- Same cycle SB_SET SB_DE=9 and WE DE=9 DATO=0xA -> mem[9]=0xA and pend[9]=1 afterwards.
- CLR pulse after writing r3=0x77 -> LISTO drops next cycle, 32 cycles later LISTO=1, r3 reads 0. RST_N asserted at INIT idx=10 -> idx restarts at 0 and the full 32-cycle count repeats.
